// File: rtl/noc_flit_interface_arbiter_mux.sv
// Merges ENTRIES upstream flit inputs onto one sender, with a round-robin, packet-locking arbiter per VC.
// Define NOC_FLIT_MUX_OUT_REG_EN to add a one-entry output register per VC; the tail bit is flit[DATA_W-1].
module noc_flit_interface_arbiter_mux #(
   parameter int CHANNELS = 2,
   parameter int ENTRIES  = 2,
   parameter int DATA_W   = 16
) (
   input  logic                                        i_clk,
   input  logic                                        i_rst_n,
   input  logic [ENTRIES-1:0][CHANNELS-1:0]             receiver_valid,
   output logic [ENTRIES-1:0][CHANNELS-1:0]             receiver_ready,
   output logic [ENTRIES-1:0][CHANNELS-1:0]             receiver_vc_ready,
   input  logic [ENTRIES-1:0][CHANNELS-1:0][DATA_W-1:0] receiver_flit,
   output logic [CHANNELS-1:0]                          sender_valid,
   input  logic [CHANNELS-1:0]                          sender_ready,
   input  logic [CHANNELS-1:0]                          sender_vc_ready,
   output logic [CHANNELS-1:0][DATA_W-1:0]              sender_flit
);

   localparam int PTR_W    = $clog2(ENTRIES);
   localparam int TAIL_BIT = DATA_W - 1;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t                        state_q [CHANNELS];
   state_t                        state_d [CHANNELS];
   logic [PTR_W-1:0]              owner_q [CHANNELS];
   logic [PTR_W-1:0]              owner_d [CHANNELS];
   logic [PTR_W-1:0]              ptr_q   [CHANNELS];
   logic [PTR_W-1:0]              ptr_d   [CHANNELS];
   logic [PTR_W-1:0]              gnt_idx_p0 [CHANNELS];
   logic [CHANNELS-1:0]           gnt_any_p0;
   logic [CHANNELS-1:0]           arb_vld_p0;
   logic [CHANNELS-1:0]           stage_rdy_p0;
   logic [CHANNELS-1:0]           accept_p0;
   logic [CHANNELS-1:0][DATA_W-1:0] arb_flit_p0;

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int step);
      int sum;
      sum = int'(base) + step;
      if (sum >= ENTRIES) sum = sum - ENTRIES;
      return PTR_W'(sum);
   endfunction

   // Stage p0: grant selection. Scanning downward lets the lowest offset from ptr win.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         gnt_any_p0[c] = 1'b0;
         gnt_idx_p0[c] = '0;
         if (state_q[c] == LOCKED) begin
            gnt_any_p0[c] = 1'b1;
            gnt_idx_p0[c] = owner_q[c];
         end else begin
            for (int k = ENTRIES - 1; k >= 0; k--) begin
               if (receiver_valid[wrap_add(ptr_q[c], k)][c]) begin
                  gnt_any_p0[c] = 1'b1;
                  gnt_idx_p0[c] = wrap_add(ptr_q[c], k);
               end
            end
         end
      end
   end

   always_comb begin
      receiver_ready = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         arb_vld_p0[c]  = gnt_any_p0[c] & receiver_valid[gnt_idx_p0[c]][c];
         arb_flit_p0[c] = receiver_flit[gnt_idx_p0[c]][c];
         accept_p0[c]   = arb_vld_p0[c] & stage_rdy_p0[c];
         for (int e = 0; e < ENTRIES; e++) begin
            if (gnt_any_p0[c] && (int'(gnt_idx_p0[c]) == e)) receiver_ready[e][c] = stage_rdy_p0[c];
         end
      end
   end

   always_comb begin
      for (int e = 0; e < ENTRIES; e++) receiver_vc_ready[e] = sender_vc_ready;
   end

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         state_d[c] = state_q[c];
         owner_d[c] = owner_q[c];
         ptr_d[c]   = ptr_q[c];
         if (accept_p0[c]) begin
            if (arb_flit_p0[c][TAIL_BIT]) begin
               state_d[c] = IDLE;
               ptr_d[c]   = wrap_add(gnt_idx_p0[c], 1);
            end else if (state_q[c] == IDLE) begin
               state_d[c] = LOCKED;
               owner_d[c] = gnt_idx_p0[c];
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            state_q[c] <= IDLE;
            owner_q[c] <= '0;
            ptr_q[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            state_q[c] <= state_d[c];
            owner_q[c] <= owner_d[c];
            ptr_q[c]   <= ptr_d[c];
         end
      end
   end

`ifdef NOC_FLIT_MUX_OUT_REG_EN
   logic [CHANNELS-1:0]             vld_p1;
   logic [CHANNELS-1:0][DATA_W-1:0] flit_p1;

   // Stage p1: one-entry output register, refilled in the same cycle it drains.
   assign stage_rdy_p0 = ~vld_p1 | sender_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p1  <= '0;
         flit_p1 <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (stage_rdy_p0[c]) begin
               vld_p1[c] <= arb_vld_p0[c];
               if (arb_vld_p0[c]) flit_p1[c] <= arb_flit_p0[c];
            end
         end
      end
   end

   assign sender_valid = vld_p1;
   assign sender_flit  = flit_p1;
`else
   assign stage_rdy_p0 = sender_ready;
   assign sender_valid = arb_vld_p0;
   assign sender_flit  = arb_flit_p0;
`endif

endmodule
